// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard controller: controller state and the
// grouped stall/flush vector handed to the pipeline registers.
package hazard_pkg;

    localparam int REG_W_DEF  = 5;
    localparam int PERF_W_DEF = 32;

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        DIV_WAIT  = 2'd1,
        EXC_DRAIN = 2'd2
    } ctrl_state_e;

    // stall[4:0] = {F, D, E, M, W}; flush[3:0] = {D, E, M, W}
    typedef struct packed {
        logic [4:0] stall;
        logic [3:0] flush;
    } stall_flush_t;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Signal bundle between the pipeline datapath (master) and the hazard
// controller (slave).
interface pipe_hazard_ctrl_if #(
    parameter int REG_W  = 5,
    parameter int PERF_W = 32
);
    logic [REG_W-1:0]  rsD, rtD, rtE, writeregE, writeregM;
    logic              branchD, regwriteE, memtoregE, memtoregM;
    logic              div_startE, div_done, i_stall, d_stall, excM, eretM;
    logic              stallF, stallD, stallE, stallM, stallW;
    logic              flushD, flushE, flushM, flushW;
    logic              pc_redirect, pc_sel_epc, div_start, div_cancel;
    logic [PERF_W-1:0] stall_cnt;

    modport master (
        output rsD, rtD, rtE, writeregE, writeregM, branchD, regwriteE,
               memtoregE, memtoregM, div_startE, div_done, i_stall, d_stall,
               excM, eretM,
        input  stallF, stallD, stallE, stallM, stallW, flushD, flushE, flushM,
               flushW, pc_redirect, pc_sel_epc, div_start, div_cancel, stall_cnt
    );

    modport slave (
        input  rsD, rtD, rtE, writeregE, writeregM, branchD, regwriteE,
               memtoregE, memtoregM, div_startE, div_done, i_stall, d_stall,
               excM, eretM,
        output stallF, stallD, stallE, stallM, stallW, flushD, flushE, flushM,
               flushW, pc_redirect, pc_sel_epc, div_start, div_cancel, stall_cnt
    );
endinterface

// File: rtl/hazard_detect.sv
// Register-index comparisons for load-use and branch-operand hazards.
module hazard_detect #(
    parameter int REG_W = 5
) (
    input  logic [REG_W-1:0] rsD,
    input  logic [REG_W-1:0] rtD,
    input  logic             branchD,
    input  logic [REG_W-1:0] rtE,
    input  logic [REG_W-1:0] writeregE,
    input  logic             regwriteE,
    input  logic             memtoregE,
    input  logic [REG_W-1:0] writeregM,
    input  logic             memtoregM,
    output logic             lw_stall,
    output logic             br_stall
);
    localparam logic [REG_W-1:0] ZERO_REG = {REG_W{1'b0}};

    logic e_hit_s;
    logic m_hit_s;

    // $0 is hardwired, so a write to it never creates a dependency
    assign lw_stall = memtoregE && (rtE != ZERO_REG) && ((rtE == rsD) || (rtE == rtD));
    assign e_hit_s  = regwriteE && (writeregE != ZERO_REG) &&
                      ((writeregE == rsD) || (writeregE == rtD));
    assign m_hit_s  = memtoregM && (writeregM != ZERO_REG) &&
                      ((writeregM == rsD) || (writeregM == rtD));
    assign br_stall = branchD && (e_hit_s || m_hit_s);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush sequencer: resolves data hazards, waits on memory and the
// divider, and defers exception flushes until AXI traffic has drained.
module pipe_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_W  = REG_W_DEF,
    parameter int PERF_W = PERF_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    pipe_hazard_ctrl_if.slave  bus
);
    localparam stall_flush_t SF_NONE = '{stall: 5'b00000, flush: 4'b0000};

    ctrl_state_e       state_q, state_d;
    logic              eret_q, eret_d;
    logic              pend_q, pend_d;
    logic [PERF_W-1:0] cnt_q, cnt_d;
    stall_flush_t      sf_s;
    logic              redir_s, sel_s, dstart_s, dcancel_s;
    logic              mem_stall_s, lw_stall_s, br_stall_s;

    hazard_detect #(.REG_W(REG_W)) u_detect (
        .rsD       (bus.rsD),
        .rtD       (bus.rtD),
        .branchD   (bus.branchD),
        .rtE       (bus.rtE),
        .writeregE (bus.writeregE),
        .regwriteE (bus.regwriteE),
        .memtoregE (bus.memtoregE),
        .writeregM (bus.writeregM),
        .memtoregM (bus.memtoregM),
        .lw_stall  (lw_stall_s),
        .br_stall  (br_stall_s)
    );

    assign mem_stall_s = bus.i_stall | bus.d_stall;

    // Priority: exception > memory wait > divider wait > data hazard
    always_comb begin
        state_d   = state_q;
        eret_d    = eret_q;
        pend_d    = pend_q;
        sf_s      = SF_NONE;
        redir_s   = 1'b0;
        sel_s     = 1'b0;
        dstart_s  = 1'b0;
        dcancel_s = 1'b0;
        case (state_q)
            RUN, DIV_WAIT: begin
                if (bus.excM) begin
                    dcancel_s = (state_q == DIV_WAIT);
                    pend_d    = 1'b0;
                    if (mem_stall_s) begin
                        sf_s.stall = 5'b11111;
                        eret_d     = bus.eretM;
                        state_d    = EXC_DRAIN;
                    end else begin
                        sf_s.flush = 4'b1111;
                        redir_s    = 1'b1;
                        sel_s      = bus.eretM;
                        state_d    = RUN;
                    end
                end else if (mem_stall_s) begin
                    sf_s.stall = 5'b11111;
                    // a completion seen during a memory wait must not be lost
                    if ((state_q == DIV_WAIT) && bus.div_done) begin
                        pend_d = 1'b1;
                    end else begin
                        pend_d = pend_q;
                    end
                end else if (state_q == DIV_WAIT) begin
                    if (bus.div_done || pend_q) begin
                        pend_d  = 1'b0;
                        state_d = RUN;
                    end else begin
                        sf_s.stall = 5'b11100;
                        sf_s.flush = 4'b0010;
                    end
                end else if (bus.div_startE) begin
                    // the divide must stay in E until its result is ready
                    dstart_s   = 1'b1;
                    sf_s.stall = 5'b11100;
                    sf_s.flush = 4'b0010;
                    state_d    = DIV_WAIT;
                end else if (lw_stall_s || br_stall_s) begin
                    sf_s.stall = 5'b11000;
                    sf_s.flush = 4'b0100;
                end else begin
                    sf_s = SF_NONE;
                end
            end
            EXC_DRAIN: begin
                if (mem_stall_s) begin
                    sf_s.stall = 5'b11111;
                end else begin
                    sf_s.flush = 4'b1111;
                    redir_s    = 1'b1;
                    sel_s      = eret_q;
                    state_d    = RUN;
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    assign cnt_d = bus.stallF ? (cnt_q + {{(PERF_W-1){1'b0}}, 1'b1}) : cnt_q;

    // State, latched ERET flag, pending divider completion and stall counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            eret_q  <= 1'b0;
            pend_q  <= 1'b0;
            cnt_q   <= {PERF_W{1'b0}};
        end else begin
            state_q <= state_d;
            eret_q  <= eret_d;
            pend_q  <= pend_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.stallF      = ~rst & sf_s.stall[4];
    assign bus.stallD      = ~rst & sf_s.stall[3];
    assign bus.stallE      = ~rst & sf_s.stall[2];
    assign bus.stallM      = ~rst & sf_s.stall[1];
    assign bus.stallW      = ~rst & sf_s.stall[0];
    assign bus.flushD      = ~rst & sf_s.flush[3];
    assign bus.flushE      = ~rst & sf_s.flush[2];
    assign bus.flushM      = ~rst & sf_s.flush[1];
    assign bus.flushW      = ~rst & sf_s.flush[0];
    assign bus.pc_redirect = ~rst & redir_s;
    assign bus.pc_sel_epc  = ~rst & sel_s;
    assign bus.div_start   = ~rst & dstart_s;
    assign bus.div_cancel  = ~rst & dcancel_s;
    assign bus.stall_cnt   = cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed-vector bench for pipe_hazard_ctrl with a queue-based scoreboard; a
// second narrow-counter instance exercises stall counter wraparound.
module tb_pipe_hazard_ctrl;

    typedef struct packed {
        logic       rst;
        logic [4:0] rsD, rtD, rtE, writeregE, writeregM;
        logic       branchD, regwriteE, memtoregE, memtoregM;
        logic       div_startE, div_done, i_stall, d_stall, excM, eretM;
    } in_t;

    typedef struct packed {
        int          step;
        logic [12:0] outs;
        logic [31:0] cnt;
        logic [2:0]  cnt3;
        logic        cnt_ok;
    } exp_t;

    // {stallF,D,E,M,W, flushD,E,M,W, pc_redirect, pc_sel_epc, div_start, div_cancel}
    localparam logic [12:0] N    = 13'b11111_0000_0000 & 13'b0;
    localparam logic [12:0] LU   = 13'b11000_0100_0000;
    localparam logic [12:0] MEM  = 13'b11111_0000_0000;
    localparam logic [12:0] MEMC = 13'b11111_0000_0001;
    localparam logic [12:0] DW   = 13'b11100_0010_0000;
    localparam logic [12:0] DST  = 13'b11100_0010_0010;
    localparam logic [12:0] FLX  = 13'b00000_1111_1000;
    localparam logic [12:0] FLE  = 13'b00000_1111_1100;
    localparam logic [12:0] FLXC = 13'b00000_1111_1001;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pipe_hazard_ctrl_if #(.REG_W(5), .PERF_W(32)) bus_m ();
    pipe_hazard_ctrl_if #(.REG_W(5), .PERF_W(3))  bus_s ();

    pipe_hazard_ctrl #(.REG_W(5), .PERF_W(32)) dut (.clk(clk), .rst(rst), .bus(bus_m));
    pipe_hazard_ctrl #(.REG_W(5), .PERF_W(3))  dut3 (.clk(clk), .rst(rst), .bus(bus_s));

    exp_t        sb_q[$];
    int          n_vec = 0;
    int          n_bad = 0;
    int          step  = 0;
    logic [31:0] cnt_m = 32'd0;
    logic [2:0]  cnt_s = 3'd0;
    logic        cnt_known = 1'b0;
    in_t         z, v;

    task automatic drive(input in_t x);
        rst = x.rst;
        bus_m.rsD = x.rsD; bus_m.rtD = x.rtD; bus_m.rtE = x.rtE;
        bus_m.writeregE = x.writeregE; bus_m.writeregM = x.writeregM;
        bus_m.branchD = x.branchD; bus_m.regwriteE = x.regwriteE;
        bus_m.memtoregE = x.memtoregE; bus_m.memtoregM = x.memtoregM;
        bus_m.div_startE = x.div_startE; bus_m.div_done = x.div_done;
        bus_m.i_stall = x.i_stall; bus_m.d_stall = x.d_stall;
        bus_m.excM = x.excM; bus_m.eretM = x.eretM;
        bus_s.rsD = x.rsD; bus_s.rtD = x.rtD; bus_s.rtE = x.rtE;
        bus_s.writeregE = x.writeregE; bus_s.writeregM = x.writeregM;
        bus_s.branchD = x.branchD; bus_s.regwriteE = x.regwriteE;
        bus_s.memtoregE = x.memtoregE; bus_s.memtoregM = x.memtoregM;
        bus_s.div_startE = x.div_startE; bus_s.div_done = x.div_done;
        bus_s.i_stall = x.i_stall; bus_s.d_stall = x.d_stall;
        bus_s.excM = x.excM; bus_s.eretM = x.eretM;
    endtask

    // Apply one vector for n cycles; expected outputs are supplied by hand,
    // expected counter value follows from the expected stallF history.
    task automatic run(input in_t x, input logic [12:0] e, input int n);
        exp_t item;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            drive(x);
            step++;
            item.step   = step;
            item.outs   = e;
            item.cnt    = cnt_m;
            item.cnt3   = cnt_s;
            item.cnt_ok = cnt_known;
            sb_q.push_back(item);
            if (x.rst) begin
                cnt_m = 32'd0;
                cnt_s = 3'd0;
                cnt_known = 1'b1;
            end else if (e[12]) begin
                cnt_m = cnt_m + 32'd1;
                cnt_s = cnt_s + 3'd1;
            end
        end
    endtask

    // Scoreboard monitor: pops one expectation per cycle, away from the clock edge
    always @(negedge clk) begin
        exp_t        item;
        logic [12:0] act;
        if (sb_q.size() > 0) begin
            item = sb_q.pop_front();
            act = {bus_m.stallF, bus_m.stallD, bus_m.stallE, bus_m.stallM, bus_m.stallW,
                   bus_m.flushD, bus_m.flushE, bus_m.flushM, bus_m.flushW,
                   bus_m.pc_redirect, bus_m.pc_sel_epc, bus_m.div_start, bus_m.div_cancel};
            n_vec++;
            if (act !== item.outs) begin
                n_bad++;
                $display("FAIL outs step %0d: got %b want %b", item.step, act, item.outs);
            end
            if (item.cnt_ok) begin
                n_vec++;
                if (bus_m.stall_cnt !== item.cnt) begin
                    n_bad++;
                    $display("FAIL stall_cnt step %0d: got %0d want %0d",
                             item.step, bus_m.stall_cnt, item.cnt);
                end
                n_vec++;
                if (bus_s.stall_cnt !== item.cnt3) begin
                    n_bad++;
                    $display("FAIL stall_cnt_wrap step %0d: got %0d want %0d",
                             item.step, bus_s.stall_cnt, item.cnt3);
                end
            end
        end
    end

    initial begin
        z = '0;
        v = z; v.rst = 1'b1;
        drive(v);
        // reset dominates even with memory stall and exception active
        run(v, N, 2);
        v.d_stall = 1'b1; v.excM = 1'b1;
        run(v, N, 1);
        run(z, N, 1);

        // load-use on rs, on rt, and with rt=$0
        v = z; v.memtoregE = 1'b1; v.rtE = 5'd2; v.rsD = 5'd2;
        run(v, LU, 1);
        run(z, N, 1);
        v = z; v.memtoregE = 1'b1; v.rtE = 5'd3; v.rtD = 5'd3;
        run(v, LU, 1);
        v = z; v.memtoregE = 1'b1; v.rtE = 5'd0; v.rsD = 5'd0;
        run(v, N, 1);

        // branch operand hazards from E, then from a load in M
        v = z; v.branchD = 1'b1; v.rsD = 5'd5; v.writeregE = 5'd5; v.regwriteE = 1'b1;
        run(v, LU, 1);
        v = z; v.branchD = 1'b1; v.rsD = 5'd5; v.writeregM = 5'd5; v.memtoregM = 1'b1;
        run(v, LU, 1);
        v = z; v.branchD = 1'b1; v.rsD = 5'd5; v.writeregE = 5'd5;
        run(v, N, 1);
        v = z; v.branchD = 1'b1; v.rtD = 5'd0; v.writeregE = 5'd0; v.regwriteE = 1'b1;
        run(v, N, 1);

        // 34-cycle divide: start cycle plus 33 wait cycles stalled, done cycle free
        v = z; v.div_startE = 1'b1;
        run(v, DST, 1);
        run(v, DW, 33);
        v.div_done = 1'b1;
        run(v, N, 1);
        run(z, N, 1);

        // single-cycle divide
        v = z; v.div_startE = 1'b1;
        run(v, DST, 1);
        v.div_done = 1'b1;
        run(v, N, 1);
        run(z, N, 1);

        // div_done during a memory stall is remembered
        v = z; v.div_startE = 1'b1;
        run(v, DST, 1);
        run(v, DW, 1);
        v.i_stall = 1'b1; v.div_done = 1'b1;
        run(v, MEM, 1);
        v.div_done = 1'b0;
        run(v, MEM, 1);
        v.i_stall = 1'b0;
        run(v, N, 1);
        v = z; v.memtoregE = 1'b1; v.rtE = 5'd2; v.rsD = 5'd2;
        run(v, LU, 1);

        // exception deferred by a 5-cycle data access; excM ignored while draining
        v = z; v.excM = 1'b1; v.d_stall = 1'b1;
        run(v, MEM, 1);
        v.eretM = 1'b1;
        run(v, MEM, 4);
        v.d_stall = 1'b0;
        run(v, FLX, 1);
        run(z, N, 1);

        // ERET variant selects EPC
        v = z; v.excM = 1'b1; v.eretM = 1'b1; v.d_stall = 1'b1;
        run(v, MEM, 1);
        v = z; v.d_stall = 1'b1;
        run(v, MEM, 2);
        run(z, FLE, 1);
        run(z, N, 1);

        // immediate exception and ERET in RUN
        v = z; v.excM = 1'b1;
        run(v, FLX, 1);
        v.eretM = 1'b1;
        run(v, FLE, 1);

        // exception in DIV_WAIT without memory stall cancels the divide
        v = z; v.div_startE = 1'b1;
        run(v, DST, 1);
        run(v, DW, 2);
        v.excM = 1'b1;
        run(v, FLXC, 1);
        v = z; v.memtoregE = 1'b1; v.rtE = 5'd7; v.rtD = 5'd7;
        run(v, LU, 1);

        // exception leaving DIV_WAIT under a fetch stall
        v = z; v.div_startE = 1'b1;
        run(v, DST, 1);
        v.excM = 1'b1; v.i_stall = 1'b1;
        run(v, MEMC, 1);
        run(z, FLX, 1);

        // memory stall outranks a load-use hazard
        v = z; v.i_stall = 1'b1; v.memtoregE = 1'b1; v.rtE = 5'd2; v.rsD = 5'd2;
        run(v, MEM, 1);

        // reset mid-divide returns to RUN without cancel, counter cleared
        v = z; v.div_startE = 1'b1;
        run(v, DST, 1);
        run(v, DW, 1);
        v.rst = 1'b1;
        run(v, N, 1);
        v = z; v.i_stall = 1'b1;
        run(v, MEM, 1);
        run(z, N, 1);
        v = z; v.i_stall = 1'b1;
        run(v, MEM, 11);
        run(z, N, 2);

        for (int k = 0; k < 5 && sb_q.size() > 0; k++) @(negedge clk);
        @(negedge clk);
        if (sb_q.size() != 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL drain: got %0d pending want 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage MIPS pipeline. It drives the stall and clear inputs of f_d_reg, d_e_reg, e_m_reg and m_w_reg, plus the PC-stage stall and redirect. It resolves load-use and branch-operand hazards, waits on AXI instruction/data memory and the multi-cycle divider, and sequences exception/ERET flushes. AXI transactions cannot be aborted, so exception flushes are deferred until memory is idle.

Parameters:
REG_W, 5, register index width
PERF_W, 32, stall performance counter width

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-high
rsD  in  REG_W  rs of instruction in D
rtD  in  REG_W  rt of instruction in D
branchD  in  1  D holds a branch/jr needing operands in D
rtE  in  REG_W  rt of instruction in E
writeregE  in  REG_W  destination register in E
regwriteE  in  1  E writes the register file
memtoregE  in  1  E is a load
writeregM  in  REG_W  destination register in M
memtoregM  in  1  M is a load
div_startE  in  1  E holds div/divu (level while in E)
div_done  in  1  divider result valid, 1-cycle pulse
i_stall  in  1  instruction AXI fetch outstanding
d_stall  in  1  data AXI access outstanding
excM  in  1  exception or ERET committed in M
eretM  in  1  the M event is ERET
stallF  out  1  hold PC
stallD  out  1  to f_d_reg.stallD
stallE  out  1  to d_e_reg.stallE
stallM  out  1  to e_m_reg.stallM
stallW  out  1  to m_w_reg.stallW
flushD  out  1  clear of f_d_reg
flushE  out  1  clear of d_e_reg
flushM  out  1  clear of e_m_reg
flushW  out  1  clear of m_w_reg
pc_redirect  out  1  load PC from exception vector or EPC
pc_sel_epc  out  1  1 = EPC (ERET), 0 = exception vector
div_start  out  1  start pulse to divider
div_cancel  out  1  abort in-flight divide
stall_cnt  out  PERF_W  count of cycles with stallF=1

Behaviour:
- State register: RUN, DIV_WAIT, EXC_DRAIN. Reset state is RUN.
- All outputs are combinational from state and inputs. stall_cnt is registered.
- While rst=1: every output is 0, stall_cnt=0, latched eret=0. Reset mid-divide returns to RUN with no div_cancel.
- mem_stall = i_stall | d_stall.
- lw_stall = memtoregE & rtE!=0 & (rtE==rsD | rtE==rtD).
- br_stall = branchD & ((regwriteE & writeregE!=0 & writeregE∈{rsD,rtD}) | (memtoregM & writeregM!=0 & writeregM∈{rsD,rtD})).
- Priority per cycle, highest first: exception > mem_stall > DIV_WAIT > lw_stall/br_stall.
- Exception in RUN or DIV_WAIT with mem_stall=0:
  - pc_redirect=1; pc_sel_epc=eretM.
  - flushD, flushE, flushM, flushW = 1.
  - div_cancel=1 if state is DIV_WAIT.
  - Next state RUN.
- Exception with mem_stall=1:
  - Latch eretM; go to EXC_DRAIN.
  - Drive all stalls=1 and no flush.
  - div_cancel=1 if leaving DIV_WAIT.
- EXC_DRAIN:
  - All stalls=1 while mem_stall=1.
  - In the first cycle with mem_stall=0: flush all, pc_redirect=1, pc_sel_epc=latched value, stalls=0; then RUN.
  - excM is ignored while in EXC_DRAIN.
- mem_stall (no exception): stallF/D/E/M/W=1, no flush, state unchanged. DIV_WAIT persists.
- RUN with div_startE=1 and mem_stall=0:
  - div_start=1 for exactly that cycle; go to DIV_WAIT.
  - div_start is never asserted in DIV_WAIT.
- DIV_WAIT, div_done=0: stallF/D/E=1, flushM=1 (bubble), stallM=stallW=0.
- DIV_WAIT, div_done=1: no stall; E advances; go to RUN.
- div_done arriving while mem_stall=1 is not lost: record it and exit DIV_WAIT on the first cycle with mem_stall=0.
- lw_stall or br_stall (RUN, no higher event): stallF=stallD=1, flushE=1, stallE/M/W=0.
- stall_cnt increments when stallF=1 and wraps modulo 2^PERF_W.

Decomposition:
- Package hazard_pkg holds the ctrl_state_e enum (RUN, DIV_WAIT, EXC_DRAIN) and a stall_flush_t packed struct (stall[4:0], flush[3:0]) consumed by the pipeline top.
- Sub-module hazard_detect holds the combinational lw_stall/br_stall comparisons. The FSM and priority logic stay in the parent.

Test Plan:
- Load-use: lw $2 in E, rsD=2 → one cycle stallF=stallD=1, flushE=1; next cycle all 0. With rtE=0 → no stall.
- Branch hazard: branchD, rsD=5, writeregE=5, regwriteE=1 → stall 1 cycle. Then load in M with writeregM=5 → stall another cycle.
- Divide: div_startE with div_done arriving 34 cycles later → div_start high in the start cycle only; stallF/D/E=1 and flushM=1 for 34 cycles; RUN afterwards. Single-cycle case: div_done in the cycle after div_start → exactly 1 DIV_WAIT cycle.
- Exception with d_stall=1 for 5 cycles → EXC_DRAIN, all stalls=1 for 5 cycles, then exactly one cycle of all flushes with pc_redirect=1. ERET variant: pc_sel_epc=1.
- Exception while in DIV_WAIT with no mem_stall → div_cancel=1 with all flushes, same cycle; state RUN.
- Assert rst in DIV_WAIT; deassert with i_stall=1 → RUN, stall_cnt=0. Counter then counts only stallF cycles. Preload near 2^32−1 → wraps to 0.
